// File: rtl/cam_ctrl.sv
// CAM controller: accepts WRITE/SEARCH/INVAL/CLEAR commands one at a time and drives
// the per-entry CAM cell strobes, tracking which entries hold live keys.
module cam_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 16,
  localparam int unsigned IDXW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  input  logic [IDXW-1:0]  cmd_idx_i,
  output logic [DEPTH-1:0] cam_write_en_o,
  output logic [WIDTH-1:0] cam_writedat_o,
  output logic             cam_search_o,
  output logic [WIDTH-1:0] cam_searchn_o,
  input  logic [DEPTH-1:0] cam_match_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_hit_o,
  output logic [IDXW-1:0]  rsp_idx_o,
  output logic             rsp_err_o,
  output logic             full_o,
  output logic [IDXW:0]    count_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  localparam logic [1:0] OpWrite  = 2'b00;
  localparam logic [1:0] OpSearch = 2'b01;
  localparam logic [1:0] OpInval  = 2'b10;
  localparam logic [1:0] OpClear  = 2'b11;

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] key_q;
  logic [IDXW-1:0]  idx_q;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic             hit_q, hit_d;
  logic [IDXW-1:0]  ridx_q, ridx_d;
  logic             err_q, err_d;

  logic             accept;
  logic             free_found;
  logic [IDXW-1:0]  free_idx;
  logic [DEPTH-1:0] match_masked;
  logic             match_found;
  logic [IDXW-1:0]  match_idx;
  logic [IDXW:0]    count;

  assign accept = cmd_valid_i && cmd_ready_o;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StResp;
      StResp:  if (rsp_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command capture; inputs are only looked at on the accepting cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= OpWrite;
      key_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      op_q  <= cmd_op_i;
      key_q <= cmd_data_i;
      idx_q <= cmd_idx_i;
    end
  end

  // Lowest free entry and lowest valid match (priority from index 0)
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
    end
  end

  assign match_masked = cam_match_i & valid_q;

  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_masked[i]) begin
        match_found = 1'b1;
        match_idx   = IDXW'(i);
      end
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + (IDXW + 1)'(valid_q[i]);
    end
  end

  // Valid-bit and response updates, all committed at the end of ISSUE
  always_comb begin
    valid_d = valid_q;
    hit_d   = hit_q;
    ridx_d  = ridx_q;
    err_d   = err_q;
    if (state_q == StIssue) begin
      hit_d  = 1'b0;
      ridx_d = '0;
      err_d  = 1'b0;
      unique case (op_q)
        OpWrite: begin
          if (free_found) begin
            valid_d[free_idx] = 1'b1;
            ridx_d            = free_idx;
          end else begin
            err_d = 1'b1;
          end
        end
        OpSearch: begin
          hit_d  = match_found;
          ridx_d = match_idx;
        end
        OpInval: begin
          valid_d[idx_q] = 1'b0;
          ridx_d         = idx_q;
          err_d          = !valid_q[idx_q];
        end
        OpClear: begin
          valid_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
      ridx_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      ridx_q  <= ridx_d;
      err_q   <= err_d;
    end
  end

  // Outputs; reset gates ready since state alone already reads as idle during reset
  always_comb begin
    cmd_ready_o    = (state_q == StIdle) && rst;
    rsp_valid_o    = (state_q == StResp);
    cam_write_en_o = '0;
    cam_writedat_o = '0;
    cam_search_o   = 1'b0;
    cam_searchn_o  = '0;
    if (state_q == StIssue) begin
      if (op_q == OpWrite && free_found) begin
        cam_write_en_o = DEPTH'(1) << free_idx;
        cam_writedat_o = key_q;
      end
      if (op_q == OpSearch) begin
        cam_search_o  = 1'b1;
        cam_searchn_o = key_q;
      end
    end
  end

  assign rsp_hit_o = hit_q;
  assign rsp_idx_o = ridx_q;
  assign rsp_err_o = err_q;
  assign count_o   = count;
  assign full_o    = (count == (IDXW + 1)'(DEPTH));

endmodule
